mix_columns_seq: RTL and testbench

//  AES MixColumns stage that sits directly downstream of shiftRows in the cipher round datapath.

---
 rtl/mix_columns_seq_pkg.sv | 22 ++
 rtl/mix_columns_seq_if.sv | 29 ++
 rtl/mix_columns_seq_mix_column_word.sv | 22 ++
 rtl/mix_columns_seq.sv | 81 ++++++++
 tb/tb_mix_columns_seq.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/mix_columns_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : mix_columns_seq_pkg
// Desc   : AES byte/word/state types and GF(2^8) helpers for MixColumns.
// Rev    : 1.0
// ============================================================================
package mix_columns_seq_pkg;

  typedef logic [7:0]       t_byte;
  typedef t_byte [3:0]      t_word;   // word[r], r = row
  typedef t_word [3:0]      t_state;  // state[c][r], c = column

  function automatic t_byte xtime(input t_byte b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic t_byte mul3(input t_byte b);
    return xtime(b) ^ b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mix_columns_seq_if.sv
`default_nettype none
// ============================================================================
// Module : mix_columns_seq_if
// Desc   : valid/ready state bus into and out of the MixColumns stage.
// Rev    : 1.0
// ============================================================================
interface mix_columns_seq_if;
  import mix_columns_seq_pkg::*;

  logic   in_valid;
  logic   in_ready;
  t_state in_state;
  logic   in_last;
  logic   out_valid;
  logic   out_ready;
  t_state out_state;

  modport master (
    output in_valid, in_state, in_last, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, in_last, out_ready,
    output in_ready, out_valid, out_state
  );

endinterface
`default_nettype wire

// File: rtl/mix_columns_seq_mix_column_word.sv
`default_nettype none
// ============================================================================
// Module : mix_column_word
// Desc   : Combinational MixColumns transform of one 4-byte column.
// Rev    : 1.0
// ============================================================================
module mix_column_word
  import mix_columns_seq_pkg::*;
(
  input  t_word in_word,
  output t_word out_word
);

  always_comb begin
    out_word[0] = xtime(in_word[0]) ^ mul3(in_word[1]) ^ in_word[2]        ^ in_word[3];
    out_word[1] = in_word[0]        ^ xtime(in_word[1]) ^ mul3(in_word[2]) ^ in_word[3];
    out_word[2] = in_word[0]        ^ in_word[1]        ^ xtime(in_word[2]) ^ mul3(in_word[3]);
    out_word[3] = mul3(in_word[0])  ^ in_word[1]        ^ in_word[2]        ^ xtime(in_word[3]);
  end

endmodule
`default_nettype wire

// File: rtl/mix_columns_seq.sv
`default_nettype none
// ============================================================================
// Module : mix_columns_seq
// Desc   : Column-serial AES MixColumns with valid/ready on both sides.
// Rev    : 1.0
// ============================================================================
module mix_columns_seq
  import mix_columns_seq_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic           clk,
  input  logic           rst,
  mix_columns_seq_if.slave bus
);

  localparam int         PASSES     = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] c_last_cnt = 2'(PASSES - 1);
  // For 4 columns per cycle this truncates to 0, harmless since col_cnt stays 0.
  localparam logic [1:0] c_n        = 2'(COLS_PER_CYCLE);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_busy = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  logic [1:0] r_fsm;
  logic [1:0] r_col_cnt;
  t_state     r_state;

  logic [1:0] w_idx     [COLS_PER_CYCLE];
  t_word      w_mix_in  [COLS_PER_CYCLE];
  t_word      w_mix_out [COLS_PER_CYCLE];
  logic       w_load;

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_mix
    localparam logic [1:0] c_k = 2'(k);
    assign w_idx[k]    = r_col_cnt * c_n + c_k;
    assign w_mix_in[k] = r_state[w_idx[k]];
    mix_column_word u_mix (
      .in_word  (w_mix_in[k]),
      .out_word (w_mix_out[k])
    );
  end

  assign bus.in_ready  = !rst && ((r_fsm == c_idle) || ((r_fsm == c_done) && bus.out_ready));
  assign bus.out_valid = (r_fsm == c_done);
  assign bus.out_state = r_state;
  assign w_load        = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm     <= c_idle;
      r_col_cnt <= 2'd0;
      r_state   <= '0;
    end else if (w_load) begin
      // in_last only steers this branch; the choice persists as the FSM path.
      r_state   <= bus.in_state;
      r_col_cnt <= 2'd0;
      r_fsm     <= bus.in_last ? c_done : c_busy;
    end else begin
      case (r_fsm)
        c_idle: ;
        c_busy: begin
          for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            r_state[w_idx[k]] <= w_mix_out[k];
          end
          if (r_col_cnt == c_last_cnt) begin
            r_col_cnt <= 2'd0;
            r_fsm     <= c_done;
          end else begin
            r_col_cnt <= r_col_cnt + 2'd1;
          end
        end
        c_done: if (bus.out_ready) r_fsm <= c_idle;
        default: r_fsm <= c_idle;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mix_columns_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_mix_columns_seq
// Desc   : Directed and streaming checks of mix_columns_seq (N = 1, 2, 4).
// Rev    : 1.0
// ============================================================================
module tb_mix_columns_seq;
  import mix_columns_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errs   = 0;

  always #5 clk = ~clk;

  mix_columns_seq_if bus1 ();
  mix_columns_seq_if bus2 ();
  mix_columns_seq_if bus4 ();

  mix_columns_seq #(.COLS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  mix_columns_seq #(.COLS_PER_CYCLE(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  t_state alt_state;
  logic   alt_valid = 1'b0;
  assign bus2.in_valid  = alt_valid;
  assign bus2.in_state  = alt_state;
  assign bus2.in_last   = 1'b0;
  assign bus2.out_ready = 1'b1;
  assign bus4.in_valid  = alt_valid;
  assign bus4.in_state  = alt_state;
  assign bus4.in_last   = 1'b0;
  assign bus4.out_ready = 1'b1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic t_word col(input t_byte b0, input t_byte b1, input t_byte b2, input t_byte b3);
    t_word w;
    w[0] = b0; w[1] = b1; w[2] = b2; w[3] = b3;
    return w;
  endfunction

  function automatic t_state st(input t_word c0, input t_word c1, input t_word c2, input t_word c3);
    t_state s;
    s[0] = c0; s[1] = c1; s[2] = c2; s[3] = c3;
    return s;
  endfunction

  // Reference model: generic shift-and-add GF(2^8) multiply over the circulant matrix.
  function automatic t_byte gmul(input t_byte a_in, input t_byte b_in);
    t_byte a = a_in, b = b_in, p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1B) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic t_state model(input t_state s, input logic last);
    t_state o;
    t_byte  coef;
    if (last) return s;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        o[c][r] = 8'h00;
        for (int j = 0; j < 4; j++) begin
          coef = (((j - r) & 3) == 0) ? 8'h02 : ((((j - r) & 3) == 1) ? 8'h03 : 8'h01);
          o[c][r] ^= gmul(coef, s[c][j]);
        end
      end
    return o;
  endfunction

  // Tasks start and end just after a falling edge.
  task automatic send(input t_state s, input logic last);
    int guard = 0;
    bus1.in_state = s;
    bus1.in_last  = last;
    bus1.in_valid = 1'b1;
    #1;
    while (!bus1.in_ready && guard < 50) begin
      @(negedge clk); #1; guard++;
    end
    check("send_ready", 128'(bus1.in_ready), 128'(1));
    @(posedge clk);
    @(negedge clk);
    bus1.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int lat, input t_state exp);
    int k = 1;
    while (!bus1.out_valid && k < 40) begin
      @(negedge clk); k++;
    end
    check({tag, "_lat"}, 128'(k), 128'(lat));
    check({tag, "_data"}, bus1.out_state, exp);
  endtask

  t_state s1, e1, s2, e2, s4, e4, held, rnd;
  t_state q[$];

  initial begin
    int lat2, lat4, sent, recv, cyc;
    logic fire;
    t_state got2, got4, exp_s;

    s1 = st(col(8'hdb,8'h13,8'h53,8'h45), col(8'hdb,8'h13,8'h53,8'h45),
            col(8'hdb,8'h13,8'h53,8'h45), col(8'hdb,8'h13,8'h53,8'h45));
    e1 = st(col(8'h8e,8'h4d,8'ha1,8'hbc), col(8'h8e,8'h4d,8'ha1,8'hbc),
            col(8'h8e,8'h4d,8'ha1,8'hbc), col(8'h8e,8'h4d,8'ha1,8'hbc));
    s2 = st(col(8'hf2,8'h0a,8'h22,8'h5c), col(8'h01,8'h01,8'h01,8'h01),
            col(8'hc6,8'hc6,8'hc6,8'hc6), col(8'hd4,8'hd4,8'hd4,8'hd5));
    e2 = st(col(8'h9f,8'hdc,8'h58,8'h9d), col(8'h01,8'h01,8'h01,8'h01),
            col(8'hc6,8'hc6,8'hc6,8'hc6), col(8'hd5,8'hd5,8'hd7,8'hd6));
    s4 = st(col(8'h2d,8'h26,8'h31,8'h4c), col(8'h2d,8'h26,8'h31,8'h4c),
            col(8'h2d,8'h26,8'h31,8'h4c), col(8'h2d,8'h26,8'h31,8'h4c));
    e4 = st(col(8'h4d,8'h7e,8'hbd,8'hf8), col(8'h4d,8'h7e,8'hbd,8'hf8),
            col(8'h4d,8'h7e,8'hbd,8'hf8), col(8'h4d,8'h7e,8'hbd,8'hf8));

    bus1.in_valid = 1'b0; bus1.in_last = 1'b0; bus1.in_state = '0; bus1.out_ready = 1'b1;
    alt_state = '0;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    check("rst_in_ready", 128'(bus1.in_ready), 128'(0));
    check("rst_out_valid", 128'(bus1.out_valid), 128'(0));
    check("rst_out_state", bus1.out_state, 128'(0));
    rst = 1'b0;
    @(negedge clk); #1;
    check("idle_in_ready", 128'(bus1.in_ready), 128'(1));
    @(negedge clk);

    // FIPS-197 column, mixed columns, pass-through
    send(s1, 1'b0); wait_out("fips", 5, e1); @(negedge clk);
    send(s2, 1'b0); wait_out("mixed", 5, e2); @(negedge clk);
    send(s2, 1'b1); wait_out("last", 1, s2); @(negedge clk);

    // Same mixed vector through the N=2 and N=4 instances
    alt_state = s2; alt_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    alt_valid = 1'b0;
    lat2 = 0; lat4 = 0; got2 = '0; got4 = '0;
    for (int k = 1; k <= 10; k++) begin
      if (bus2.out_valid && lat2 == 0) begin lat2 = k; got2 = bus2.out_state; end
      if (bus4.out_valid && lat4 == 0) begin lat4 = k; got4 = bus4.out_state; end
      @(negedge clk);
    end
    check("n2_lat", 128'(lat2), 128'(3));
    check("n2_data", got2, e2);
    check("n4_lat", 128'(lat4), 128'(2));
    check("n4_data", got4, e4 ^ e4 ^ e2);

    // Backpressure, then back-to-back accept
    bus1.out_ready = 1'b0;
    send(s1, 1'b0); wait_out("bp", 5, e1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      check("bp_hold", bus1.out_state, e1);
      check("bp_in_ready", 128'(bus1.in_ready), 128'(0));
    end
    check("bp_valid", 128'(bus1.out_valid), 128'(1));
    bus1.out_ready = 1'b1; bus1.in_state = s4; bus1.in_last = 1'b0; bus1.in_valid = 1'b1;
    #1;
    check("b2b_in_ready", 128'(bus1.in_ready), 128'(1));
    send(s4, 1'b0); wait_out("b2b", 5, e4); @(negedge clk);

    // Reset mid-BUSY
    send(s1, 1'b0);
    @(negedge clk);
    rst = 1'b1; #1;
    check("rbusy_valid", 128'(bus1.out_valid), 128'(0));
    check("rbusy_in_ready", 128'(bus1.in_ready), 128'(0));
    @(negedge clk); rst = 1'b0; #1;
    check("rbusy_idle", 128'(bus1.in_ready), 128'(1));
    check("rbusy_cleared", bus1.out_state, 128'(0));
    @(negedge clk);
    send(s1, 1'b0); wait_out("post_rst", 5, e1); @(negedge clk);

    // Reset mid-DONE
    bus1.out_ready = 1'b0;
    send(s2, 1'b0); wait_out("rdone_pre", 5, e2);
    rst = 1'b1; #1;
    check("rdone_valid", 128'(bus1.out_valid), 128'(0));
    @(negedge clk); rst = 1'b0; bus1.out_ready = 1'b1;
    @(negedge clk);

    // Random streaming against the reference model
    sent = 0; recv = 0; cyc = 0;
    while ((sent < 100 || q.size() != 0) && cyc < 20000) begin
      if (!bus1.in_valid && sent < 100 && $urandom_range(0, 2) != 0) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            rnd[c][r] = 8'($urandom_range(0, 255));
        bus1.in_state = rnd;
        bus1.in_last  = ($urandom_range(0, 3) == 0);
        bus1.in_valid = 1'b1;
      end
      bus1.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      fire = 1'b0;
      if (bus1.out_valid && bus1.out_ready) begin
        exp_s = (q.size() != 0) ? q.pop_front() : ~bus1.out_state;
        check("stream_data", bus1.out_state, exp_s);
        recv++;
      end
      if (bus1.in_valid && bus1.in_ready) begin
        q.push_back(model(bus1.in_state, bus1.in_last));
        sent++;
        fire = 1'b1;
      end
      @(posedge clk); @(negedge clk);
      if (fire) bus1.in_valid = 1'b0;
      cyc++;
    end
    check("stream_count", 128'(recv), 128'(100));
    check("stream_left", 128'(q.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
